// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the ASCII-to-glyph table for the scrolling seven-segment controller.
package seven_seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t       SEG_BLANK   = 8'hFF;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Glyphs are built active-high {dp,g,f,e,d,c,b,a} and inverted for the active-low pins.
    // Lower-case letters fold onto the upper-case glyphs.
    function automatic seg_t ascii_to_seg(input logic [7:0] c);
        logic [7:0] u;
        logic [7:0] on;
        u  = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        on = 8'h00;
        case (u)
            "0": on = 8'h3F;  "1": on = 8'h06;  "2": on = 8'h5B;  "3": on = 8'h4F;
            "4": on = 8'h66;  "5": on = 8'h6D;  "6": on = 8'h7D;  "7": on = 8'h07;
            "8": on = 8'h7F;  "9": on = 8'h6F;
            "A": on = 8'h77;  "B": on = 8'h7C;  "C": on = 8'h39;  "D": on = 8'h5E;
            "E": on = 8'h79;  "F": on = 8'h71;  "G": on = 8'h3D;  "H": on = 8'h76;
            "I": on = 8'h30;  "J": on = 8'h1E;  "K": on = 8'h75;  "L": on = 8'h38;
            "M": on = 8'h15;  "N": on = 8'h54;  "O": on = 8'h3F;  "P": on = 8'h73;
            "Q": on = 8'h67;  "R": on = 8'h50;  "S": on = 8'h6D;  "T": on = 8'h78;
            "U": on = 8'h3E;  "V": on = 8'h1C;  "W": on = 8'h2A;  "X": on = 8'h64;
            "Y": on = 8'h6E;  "Z": on = 8'h5B;
            "-": on = 8'h40;  "_": on = 8'h08;  "=": on = 8'h48;  ".": on = 8'h80;
            "'": on = 8'h02;  "\"": on = 8'h22;
            default: on = 8'h00;
        endcase
        return ~on;
    endfunction

endpackage

// File: rtl/seven_seg_char_encoder.sv
// Combinational ASCII byte to active-low seven-segment glyph.
module seven_seg_char_encoder
    import seven_seg_pkg::*;
(
    input  logic [7:0] ascii,
    output seg_t       glyph
);

    assign glyph = ascii_to_seg(ascii);

endmodule

// File: rtl/seven_seg_scroll_control.sv
// Multi-display seven-segment scanner with a byte-loaded, circularly scrolling message buffer.
// Optional macro SEVEN_SEG_BRIGHTNESS_EN adds a 4-bit brightness input that dims the anodes.
module seven_seg_scroll_control
    import seven_seg_pkg::*;
#(
    parameter int DISPLAYS        = 2,
    parameter int DIGITS          = 4,
    parameter int MSG_LEN         = 16,
    parameter int REFRESH_DIVISOR = 208333,
    parameter int SCROLL_DIVISOR  = 25000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    input  logic [3:0]                   brightness,
`endif
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_data,
    output logic                         wr_ready,
    input  logic                         clear,
    input  logic                         scroll_en,
    output logic [DISPLAYS*DIGITS-1:0]   digit_select,
    output logic [DISPLAYS*8-1:0]        seg
);

    localparam int W     = DISPLAYS * DIGITS;
    localparam int G_W   = (W > 1) ? $clog2(W) : 1;
    localparam int K_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int LEN_W = $clog2(MSG_LEN + 1);
    localparam int RC_W  = (REFRESH_DIVISOR > 1) ? $clog2(REFRESH_DIVISOR) : 1;
    localparam int SC_W  = (SCROLL_DIVISOR > 1) ? $clog2(SCROLL_DIVISOR) : 1;

    logic [7:0]        msg_buf [MSG_LEN];
    logic [LEN_W-1:0]  length;
    logic [IDX_W-1:0]  offset;
    logic [K_W-1:0]    scan_idx;
    logic [RC_W-1:0]   refresh_cnt;
    logic [SC_W-1:0]   scroll_cnt;

    logic              refresh_tc;
    logic              scroll_tc;
    logic              wr_fire;
    logic              scrolling;
    logic              slot_lit;

    logic [7:0]        char_sel [DISPLAYS];
    seg_t              glyph    [DISPLAYS];
    logic [W-1:0]      anode_p0;
    logic [DISPLAYS*8-1:0] seg_p0;
    logic [G_W-1:0]    g_idx;
    int                pos_i;
    int                sum_i;

    assign refresh_tc = (refresh_cnt == RC_W'(REFRESH_DIVISOR - 1));
    assign scroll_tc  = (scroll_cnt == SC_W'(SCROLL_DIVISOR - 1));
    assign wr_ready   = (length < LEN_W'(MSG_LEN)) && !clear;
    assign wr_fire    = wr_valid && wr_ready;
    assign scrolling  = (int'(length) > W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scroll_cnt  <= '0;
            scan_idx    <= '0;
            offset      <= '0;
            length      <= '0;
        end else begin
            refresh_cnt <= refresh_tc ? '0 : refresh_cnt + 1'b1;
            scroll_cnt  <= scroll_tc ? '0 : scroll_cnt + 1'b1;
            if (clear) begin
                scan_idx <= '0;
                offset   <= '0;
                length   <= '0;
            end else begin
                if (refresh_tc)
                    scan_idx <= (scan_idx == K_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
                // Wrap test uses the pre-write length; the read side re-applies modulo next cycle.
                if (!scrolling)
                    offset <= '0;
                else if (scroll_tc && scroll_en)
                    offset <= (int'(offset) + 1 >= int'(length)) ? '0 : offset + 1'b1;
                if (wr_fire)
                    length <= length + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= ASCII_SPACE;
        end else if (clear) begin
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= ASCII_SPACE;
        end else if (wr_fire) begin
            msg_buf[length[IDX_W-1:0]] <= wr_data;
        end
    end

    // Position p = W-1-g; offset+p < 2*length, so one conditional subtract replaces the modulo.
    always_comb begin
        pos_i = 0;
        sum_i = 0;
        for (int d = 0; d < DISPLAYS; d++) begin
            char_sel[d] = ASCII_SPACE;
            pos_i = W - 1 - (d * DIGITS + int'(scan_idx));
            sum_i = int'(offset) + pos_i;
            if (sum_i >= int'(length)) sum_i = sum_i - int'(length);
            if (scrolling)
                char_sel[d] = msg_buf[IDX_W'(sum_i)];
            else if (pos_i < int'(length))
                char_sel[d] = msg_buf[IDX_W'(pos_i)];
        end
    end

    for (genvar d = 0; d < DISPLAYS; d++) begin : g_disp
        seven_seg_char_encoder u_enc (
            .ascii (char_sel[d]),
            .glyph (glyph[d])
        );
        assign seg_p0[d*8 +: 8] = glyph[d];
    end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]  bright_q;
    logic [31:0] lit_thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bright_q <= 4'hF;
        else if (refresh_tc)
            bright_q <= brightness;
    end

    assign lit_thresh = ((32'(bright_q) + 32'd1) * 32'(REFRESH_DIVISOR)) >> 4;
    assign slot_lit   = (32'(refresh_cnt) < lit_thresh);
`else
    assign slot_lit = 1'b1;
`endif

    always_comb begin
        anode_p0 = '1;
        g_idx    = '0;
        for (int d = 0; d < DISPLAYS; d++) begin
            g_idx           = G_W'(d * DIGITS + int'(scan_idx));
            anode_p0[g_idx] = !slot_lit;
        end
    end

    // ---- output register stage: anodes and segments move together ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_select <= '1;
            seg          <= '1;
        end else begin
            digit_select <= anode_p0;
            seg          <= seg_p0;
        end
    end

endmodule
